// File: rtl/debounce_scan_ctrl.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl
//
// Purpose:
//   Bus master for a set of debouncer boards sharing one 3-bit select bus
//   (a_bus) and one 8-bit result bus (bus_data). Slots 0..NUM_SLOTS-1 are
//   addressed round-robin. Each slot is driven for SETTLE cycles, sampled,
//   and compared with a stored image. Changes are queued as events in a
//   first-word-fall-through FIFO that is drained with a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   en            scan enable
//   bus_data[7:0] shared debouncer output bus
//   a_bus[2:0]    slot select onto the debouncer aBus
//   bus_oe        high while a slot is being addressed
//   evt_valid     FIFO head valid
//   evt_ready     consumer accepts the head event
//   evt_slot[2:0] slot of the head event
//   evt_data[7:0] newly sampled byte of the head event
//   evt_mask[7:0] changed bits of the head event (new XOR old)
//   overflow      sticky flag: a change was dropped because the FIFO was full
//   clr_overflow  clears overflow (a new drop in the same cycle wins)
// -----------------------------------------------------------------------------
module debounce_scan_ctrl #(
  parameter int NUM_SLOTS  = 8,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] bus_data,
  output logic [2:0] a_bus,
  output logic       bus_oe,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_slot,
  output logic [7:0] evt_data,
  output logic [7:0] evt_mask,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [2:0]        LAST_SLOT   = 3'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [FCNT_W-1:0] DEPTH_CNT   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_COMPARE
  } state_t;

  // Scan state
  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [2:0]       a_bus_q, a_bus_d;
  logic             bus_oe_q, bus_oe_d;
  logic [7:0]       sample_q, sample_d;
  logic [7:0][7:0]  image_q, image_d;
  logic [7:0]       primed_q, primed_d;

  // Event FIFO state
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [18:0]       fifo_mem [FIFO_DEPTH];

  // Compare-stage decisions
  logic [7:0] diff;
  logic       changed;
  logic       pop;
  logic       push_ok;
  logic       push;
  logic       ovf_set;
  logic [2:0] next_slot;

  assign diff      = sample_q ^ image_q[slot_q];
  assign pop       = (count_q != '0) && evt_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts the new event.
  assign push_ok   = (count_q < DEPTH_CNT) || pop;
  assign changed   = (state_q == S_COMPARE) && primed_q[slot_q] && (diff != '0);
  assign push      = changed && push_ok;
  assign ovf_set   = changed && !push_ok;
  assign next_slot = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d  = state_q;
    slot_d   = slot_q;
    settle_d = settle_q;
    a_bus_d  = a_bus_q;
    bus_oe_d = bus_oe_q;
    sample_d = sample_q;
    image_d  = image_q;
    primed_d = primed_q;

    unique case (state_q)
      S_IDLE: begin
        bus_oe_d = 1'b0;
        if (en) begin
          state_d  = S_DRIVE;
          settle_d = SETTLE_LOAD;
          a_bus_d  = slot_q;
          bus_oe_d = 1'b1;
        end
      end

      S_DRIVE: begin
        if (settle_q == '0) begin
          // Last settle cycle: capture the bus as this cycle ends.
          sample_d = bus_data;
          state_d  = S_COMPARE;
          bus_oe_d = 1'b0;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end

      S_COMPARE: begin
        if (!primed_q[slot_q]) begin
          image_d[slot_q]  = sample_q;
          primed_d[slot_q] = 1'b1;
        end else if (push) begin
          image_d[slot_q] = sample_q;
        end
        // A dropped change leaves the image stale so the next pass sees it again.
        slot_d = next_slot;
        if (en) begin
          state_d  = S_DRIVE;
          settle_d = SETTLE_LOAD;
          a_bus_d  = next_slot;
          bus_oe_d = 1'b1;
        end else begin
          state_d  = S_IDLE;
          bus_oe_d = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        bus_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase

    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      slot_q     <= 3'd0;
      settle_q   <= '0;
      a_bus_q    <= 3'd0;
      bus_oe_q   <= 1'b0;
      sample_q   <= 8'd0;
      image_q    <= '0;
      primed_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      settle_q   <= settle_d;
      a_bus_q    <= a_bus_d;
      bus_oe_q   <= bus_oe_d;
      sample_q   <= sample_d;
      image_q    <= image_d;
      primed_q   <= primed_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only visible
  // when count_q says they are valid, and the head outputs are gated below.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {slot_q, sample_q, diff};
    end
  end

  logic [18:0] head;
  assign head = fifo_mem[rd_ptr_q];

  assign a_bus     = a_bus_q;
  assign bus_oe    = bus_oe_q;
  assign evt_valid = (count_q != '0);
  assign evt_slot  = evt_valid ? head[18:16] : 3'd0;
  assign evt_data  = evt_valid ? head[15:8]  : 8'd0;
  assign evt_mask  = evt_valid ? head[7:0]   : 8'd0;
  assign overflow  = overflow_q;

endmodule
